// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the programmable sequence generator:
// state encoding, mode encoding and the power-up sequence table contents.
`default_nettype none

package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_LOOP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    localparam int unsigned DEFAULT_LEN = 6;
    localparam int unsigned DEFAULT_SEQ [DEFAULT_LEN] = '{0, 8, 5, 3, 7, 2};

    // Entries beyond the default sequence power up as zero.
    function automatic int unsigned default_entry(input int unsigned i);
        if (i < DEFAULT_LEN) begin
            return DEFAULT_SEQ[i];
        end
        return 0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/t_ff_bank.sv
// Output register built from toggle flip-flops; toggling the bits where the
// current value differs from target makes a load behave like a D register.
`default_nettype none

module t_ff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] toggle;

    assign toggle = load ? (q_q ^ target) : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_q ^ toggle;
        end
    end

    assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/seq_gen_prog.sv
// Programmable sequence generator: steps Yt through a rewritable table with
// variable length, loop/one-shot mode, enable/hold and start/stop control.
`default_nettype none

module seq_gen_prog
    import seq_gen_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    input  logic [AW:0]      len,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] Yt,
    output logic [WIDTH-1:0] Yt1,
    output logic [AW-1:0]    idx,
    output logic             busy,
    output logic             done
);

    localparam int RST_LEN = (int'(DEFAULT_LEN) > DEPTH) ? DEPTH : int'(DEFAULT_LEN);

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW:0]      len_q, len_d;
    logic             mode_q, mode_d;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] table_q [DEPTH];

    logic             last_entry;
    logic [AW-1:0]    next_idx;
    logic [WIDTH-1:0] preview;
    logic             load;
    logic [WIDTH-1:0] target;
    logic             addr_ok;

    function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
        if (l == '0) begin
            return (AW+1)'(1);
        end else if (int'(l) > DEPTH) begin
            return (AW+1)'(DEPTH);
        end
        return l;
    endfunction

    assign last_entry = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));
    assign next_idx   = last_entry ? '0 : (idx_q + AW'(1));

    // A one-shot run parked on its last entry has nowhere to go, so preview it.
    assign preview = (last_entry && (mode_q == MODE_ONESHOT)) ? table_q[idx_q]
                                                              : table_q[next_idx];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        mode_d  = mode_q;
        load    = 1'b0;
        target  = table_q[0];

        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            len_d   = clamp_len(len);
            mode_d  = mode;
            idx_d   = '0;
            load    = 1'b1;
            target  = table_q[0];
            state_d = RUN;
        end else if ((state_q == RUN) && en) begin
            if (last_entry && (mode_q == MODE_ONESHOT)) begin
                state_d = DONE;
            end else begin
                idx_d  = next_idx;
                load   = 1'b1;
                target = table_q[next_idx];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= (AW+1)'(RST_LEN);
            mode_q  <= MODE_LOOP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign addr_ok = (int'(wr_addr) < DEPTH);

    // Reads above see the pre-write contents, giving read-before-write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= WIDTH'(default_entry(i));
            end
        end else if (wr_en && addr_ok) begin
            table_q[wr_addr] <= wr_data;
        end
    end

    t_ff_bank #(
        .WIDTH (WIDTH)
    ) u_out (
        .clock  (clock),
        .reset  (reset),
        .load   (load),
        .target (target),
        .q      (Yt)
    );

    assign Yt1  = (state_q == RUN) ? preview : table_q[0];
    assign idx  = idx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_gen_prog.sv
// Scoreboard bench for seq_gen_prog: a behavioural model predicts each cycle's
// outputs into a queue, and a monitor pops and compares after every edge.
`default_nettype none

module tb_seq_gen_prog;

    localparam int WIDTH = 4;
    localparam int DEPTH = 6;
    localparam int AW    = $clog2(DEPTH);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0, mode = 1'b0, start = 1'b0, stop = 1'b0;
    logic [AW:0]      len = '0;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [WIDTH-1:0] Yt, Yt1;
    logic [AW-1:0]    idx;
    logic             busy, done;

    seq_gen_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .en(en), .mode(mode), .start(start),
        .stop(stop), .len(len), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .Yt(Yt), .Yt1(Yt1), .idx(idx), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int yt;
        int yt1;
        int idx;
        int busy;
        int done;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model: table contents, phase (0 idle, 1 running, 2 finished).
    int m_tab [DEPTH];
    int m_phase, m_len, m_mode, m_idx, m_yt;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        int dflt [6] = '{0, 8, 5, 3, 7, 2};
        for (int i = 0; i < DEPTH; i++) m_tab[i] = (i < 6) ? (dflt[i] % (1 << WIDTH)) : 0;
        m_phase = 0; m_len = (DEPTH < 6) ? DEPTH : 6; m_mode = 0; m_idx = 0; m_yt = 0;
    endfunction

    function automatic int model_preview();
        if (m_phase != 1) return m_tab[0];
        if (m_idx < m_len - 1) return m_tab[m_idx + 1];
        if (m_mode == 0) return m_tab[0];
        return m_tab[m_idx];
    endfunction

    task automatic step(input bit r, input bit e, input bit md, input bit st, input bit sp,
                        input int l, input bit we, input int wa, input int wd);
        exp_t x;
        @(negedge clock);
        reset = r; en = e; mode = md; start = st; stop = sp; len = (AW+1)'(l);
        wr_en = we; wr_addr = AW'(wa); wr_data = WIDTH'(wd);
        if (r) begin
            model_reset();
        end else begin
            if (sp) begin
                m_phase = 0;
            end else if (st) begin
                m_len = (l == 0) ? 1 : ((l > DEPTH) ? DEPTH : l);
                m_mode = md; m_idx = 0; m_yt = m_tab[0]; m_phase = 1;
            end else if (m_phase == 1 && e) begin
                if (m_idx < m_len - 1) begin
                    m_idx++; m_yt = m_tab[m_idx];
                end else if (m_mode == 0) begin
                    m_idx = 0; m_yt = m_tab[0];
                end else begin
                    m_phase = 2;
                end
            end
            if (we && wa < DEPTH) m_tab[wa] = wd % (1 << WIDTH);
        end
        x.yt = m_yt; x.yt1 = model_preview(); x.idx = m_idx;
        x.busy = (m_phase == 1) ? 1 : 0; x.done = (m_phase == 2) ? 1 : 0;
        sb.push_back(x);
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) step(0, e, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic go(input int l, input bit md);
        step(0, 1, md, 1, 0, l, 0, 0, 0);
    endtask

    task automatic wr(input int a, input int d);
        step(0, 0, 0, 0, 0, 0, 1, a, d);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clock);
            #2;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("Yt",   int'(Yt),   x.yt);
                chk("Yt1",  int'(Yt1),  x.yt1);
                chk("idx",  int'(idx),  x.idx);
                chk("busy", int'(busy), x.busy);
                chk("done", int'(done), x.done);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        model_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);

        // Default loop, wrap 5 -> 0
        go(6, 0); run(13, 1);
        // One-shot of three, then restart
        go(3, 1); run(5, 1); go(3, 1); run(2, 1);
        // Hold with en low at Yt=5, resume, stop at 3, en ignored in IDLE
        go(6, 0); run(2, 1); run(3, 0); run(1, 1);
        step(0, 1, 0, 0, 1, 0, 0, 0, 0); run(3, 1);

        // Rewritten table, read-before-write on entry 2, out-of-range writes
        wr(0, 15); wr(1, 1); wr(2, 14); wr(3, 2); wr(6, 9); wr(7, 9);
        go(4, 0); run(1, 1);
        step(0, 1, 0, 0, 0, 0, 1, 2, 9);
        run(6, 1);

        // Length boundaries and stop over start
        go(0, 0); run(4, 1);
        go(DEPTH + 3, 0); run(10, 1);
        step(0, 1, 0, 1, 1, 4, 0, 0, 0); run(2, 1);

        // Asynchronous reset between edges
        go(6, 0); run(3, 1);
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        chk("async_Yt", int'(Yt), 0);
        chk("async_idx", int'(idx), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        model_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        go(6, 0); run(7, 1);

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            step(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
                 $urandom_range(0, 9), ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 7), $urandom_range(0, 15));
        end

        @(posedge clock); #4;
        chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_gen_prog.md
Name: seq_gen_prog

Overview:
Parametrised programmable binary sequence generator, the successor to the fixed six-state T-flip-flop sequence generator. It steps an output register through a sequence held in an internal table that software can rewrite. It supports variable sequence length, loop or one-shot mode, enable/hold, and start/stop control. The output register is built from a T-flip-flop bank (T = current XOR target). It sits beside the lab counters as a stimulus and pattern source.

Parameters:
WIDTH, 4, bit width of each sequence value and of the output
DEPTH, 8, number of table entries (must be ≥ 2)
AW, $clog2(DEPTH), width of table address, index and length ports (derived; not overridden)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  advance enable; 0 freezes the sequence in RUN
mode  input  1  0 = loop, 1 = one-shot; sampled on start
start  input  1  begin/restart sequence at entry 0
stop  input  1  abort to IDLE; output holds
len  input  AW+1  active entry count; sampled on start
wr_en  input  1  table write strobe
wr_addr  input  AW  table write address
wr_data  input  WIDTH  table write data
Yt  output  WIDTH  current sequence value (registered)
Yt1  output  WIDTH  preview of the value Yt takes on the next advance (combinational)
idx  output  AW  current table index
busy  output  1  high in RUN
done  output  1  high in DONE

Behaviour:
- Reset (async, immediate, also mid-run):
  - state = IDLE; Yt = 0; idx = 0; busy = 0; done = 0.
  - Table = {0,8,5,3,7,2}, remaining entries 0 (values truncated/zero-extended to WIDTH).
  - Captured len = 6 (clamped to DEPTH); captured mode = 0.
- States: IDLE, RUN, DONE. busy = (state == RUN); done = (state == DONE). Both are registered state decodes.
- Control priority per edge: stop > start > advance.
- stop=1: state → IDLE; Yt and idx hold.
- start=1 (any state):
  - Capture len_q = clamp(len): 0 → 1, len > DEPTH → DEPTH.
  - Capture mode_q.
  - idx ← 0; Yt ← table[0]; state → RUN. One-cycle latency from start to Yt valid.
- RUN, en=1, no start/stop:
  - If idx < len_q−1: idx ← idx+1; Yt ← table[idx+1].
  - If idx == len_q−1 and mode_q = 0: idx ← 0; Yt ← table[0] (wrap).
  - If idx == len_q−1 and mode_q = 1: state → DONE; Yt and idx hold.
- RUN, en=0: everything holds.
- len_q = 1 in loop mode: Yt reloads table[0] every enabled cycle.
- IDLE and DONE: Yt and idx hold; only start exits.
- Yt1:
  - In RUN: equals the table value selected by the advance rule above.
  - In IDLE or DONE: equals table[0].
- Output register: implemented as a WIDTH-bit T-FF bank with T = Yt XOR target and load = advance|start. It is functionally identical to a D register.
- Table writes:
  - Accepted in any state when wr_en=1 and wr_addr < DEPTH; out-of-range addresses are ignored.
  - Write and read of the same entry in one cycle: Yt loads the old value (read-before-write); the new value is visible from the next cycle.
  - Writes never change len_q, mode_q, idx or state.
- Simultaneous start and wr_en to entry 0: Yt gets the old table[0].

Decomposition:
- Package seq_gen_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Default sequence constant array {0,8,5,3,7,2}.
  - MODE_LOOP = 0, MODE_ONESHOT = 1.
- Sub-module t_ff_bank (parameter WIDTH; ports clock, reset, load, target, q): holds the output register.
- Table, index and FSM stay in seq_gen_prog.

Test Plan:
- Reset, then start=1 with len=6, mode=0, en=1 held → Yt = 0,8,5,3,7,2,0,8,… from the cycle after start; busy=1; idx wraps 5→0.
- One-shot: mode=1, len=3 → Yt = 0,8,5, then done=1, busy=0; Yt holds 5; Yt1 = 0; a new start gives Yt = 0, busy=1.
- en toggling: en=0 for 3 cycles mid-run at Yt=5 → Yt and idx frozen; resumes with 3 next. stop at Yt=3 → IDLE, Yt=3 held; en has no effect.
- Table rewrite: write entries 0..3 = F,1,E,2 (WIDTH=4), len=4, loop → F,1,E,2,F…. Write entry 2 in the same cycle Yt loads entry 2 → old value appears; the next lap shows the new value. wr_addr ≥ DEPTH → table unchanged.
- Boundaries: len=0 → behaves as len=1, Yt stays table[0]. len=DEPTH+3 → wraps at DEPTH−1. Simultaneous stop and start → IDLE.
- Async reset asserted mid-RUN between clock edges → Yt=0, idx=0, busy=0 immediately; table restored to the default sequence.
